branch_resolve_unit: RTL and testbench
======================================

# branch_resolve_unit

Decode-side partner of the fetch stage: consumes each fetched instruction and its sequential PC, detects control-transfer instructions, evaluates the branch condition with register-file operands one cycle later, and drives `next_pc_out` / `jump_branch_out` back into fetch. It also produces the link address for `jal`/`jalr` and flags misaligned register-indirect targets. MIPS single-delay-slot semantics apply.

## Interface
Parameters:
- `RESET_PC`, `32'h00400000`: reserved for future use; unused in this revision.

Ports:
- `clk`  in  1  — single clock; all state updates on rising edge.
- `reset`  in  1  — asynchronous, active-low; forces IDLE and clears all registers immediately.
- `instr_in`  in  32  — instruction currently presented by fetch.
- `pc_seq_in`  in  32  — address of `instr_in` + 4.
- `stall_in`  in  1  — 1 = fetch is stalled and inserting a nop. Do not capture, and do not advance past REDIRECT.
- `rs_data_in`, `rt_data_in`  in  32 each  — register-file read data for the captured instruction, valid in RESOLVE.
- `next_pc_out`  out  32  — next PC to fetch.
- `jump_branch_out`  out  1  — 1 while a taken redirect is being presented.
- `link_valid_out`  out  1  — 1-cycle pulse in RESOLVE for `jal`/`jalr`.
- `link_addr_out`  out  32  — captured `pc_seq` + 4; meaningful when `link_valid_out` = 1.
- `misalign_out`  out  1  — 1-cycle pulse in RESOLVE when a `jr`/`jalr` target has bits [1:0] ≠ 0.

## Operation
- Control-transfer opcodes:
  - `beq` 0x04: taken when rs == rt.
  - `bne` 0x05: taken when rs != rt.
  - `blez` 0x06: taken when signed rs <= 0.
  - `bgtz` 0x07: taken when signed rs > 0.
  - `j` 0x02 and `jal` 0x03: always taken.
  - SPECIAL 0x00 with funct `jr` 0x08 or `jalr` 0x09: always taken.
  - All other encodings are non-control and are ignored.
- Targets, all 32-bit and wrapping modulo 2^32:
  - Branch: `pc_seq_q + (sign_ext(imm16) << 2)`.
  - Jump: `{pc_seq_q[31:28], instr_q[25:0], 2'b00}`.
  - Register: `{rs_data_in[31:2], 2'b00}`. Low bits are cleared and `misalign_out` pulses if they were nonzero.
- FSM states: IDLE, RESOLVE, REDIRECT.
  - IDLE → RESOLVE when `stall_in` = 0 and `instr_in` is control-transfer. `instr_in` and `pc_seq_in` are captured into `instr_q`/`pc_seq_q`.
  - RESOLVE is held while `stall_in` = 1; the operands must remain valid.
  - When `stall_in` = 0 in RESOLVE: if taken, latch `target_q` and go to REDIRECT; otherwise go to IDLE. `link_valid_out` and `misalign_out` pulse only on this advancing cycle.
  - REDIRECT → IDLE on the first cycle with `stall_in` = 0. While `stall_in` = 1, stay in REDIRECT with outputs held.
- Instructions presented during RESOLVE (the delay slot) and during REDIRECT are never decoded as control transfers. A branch in a delay slot is architecturally undefined and is ignored.
- Output selection:
  - `next_pc_out` = `target_q` in REDIRECT, otherwise `pc_seq_in` (combinational passthrough).
  - `jump_branch_out` = (state == REDIRECT).

## Timing
- Cycle N: branch on `instr_in`, captured at the end of N.
- Cycle N+1: RESOLVE; the delay slot is on `instr_in`.
- Cycle N+2: REDIRECT, with `jump_branch_out` = 1 and `next_pc_out` = target. Each stall cycle adds exactly one cycle of latency.
- Not-taken branch: zero redirect cycles; `next_pc_out` stays the passthrough throughout.
- Reset values while `reset` = 0:
  - state = IDLE.
  - `jump_branch_out` = 0, `link_valid_out` = 0, `misalign_out` = 0.
  - `link_addr_out` = 0.
  - `next_pc_out` = `pc_seq_in`.
- Reset asserted in RESOLVE or REDIRECT aborts the transfer: no redirect and no pulses after release.
- Back-to-back control transfers: a branch presented in the cycle immediately after REDIRECT exits is captured normally.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - opcode/funct localparams (`OP_BEQ`, `OP_BNE`, `OP_BLEZ`, `OP_BGTZ`, `OP_J`, `OP_JAL`, `OP_SPECIAL`, `FN_JR`, `FN_JALR`);
  - the state enum `br_state_t`.
- One combinational sub-module, `branch_cond_eval`: inputs opcode, rs, rt; output `taken`. It is shared with the future execute-stage comparator.
- Registers: `instr_q`, `pc_seq_q`, `target_q`, state.

## Test plan
- `beq` with `pc_seq_in` = 0x00400014, imm = 0x0003, rs = rt = 5 → in N+2, `jump_branch_out` = 1 and `next_pc_out` = 0x00400020 for one cycle.
- `bne` with rs = rt = 7 → `jump_branch_out` stays 0 and `next_pc_out` tracks `pc_seq_in` every cycle.
- `j` 0x08100040 with `pc_seq_in` = 0x00400104 → redirect to 0x00400100; `beq` with imm = 0xFFFF and `pc_seq_in` = 0x00400010 → redirect to 0x0040000C.
- `jalr` with `pc_seq_in` = 0x00400200 and rs = 0x00400102 → in RESOLVE, `link_valid_out` = 1, `link_addr_out` = 0x00400204, `misalign_out` = 1; then redirect to 0x00400100.
- Taken `bgtz` (rs = 1) with `stall_in` = 1 for 3 cycles in REDIRECT → `jump_branch_out` is held for 4 cycles and drops after the first unstalled cycle.
- `reset` pulsed low during RESOLVE of a taken `beq` → no redirect afterwards; all outputs at reset values and the FSM in IDLE.

Source files
------------

// File: rtl/mips_ctrl_pkg.sv
// Shared MIPS control-transfer definitions: opcode/funct encodings, the
// branch-resolve FSM state type and small instruction-classification helpers.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;

    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_RESOLVE  = 2'd1,
        ST_REDIRECT = 2'd2
    } br_state_t;

    // Register-indirect jump (jr / jalr)
    function automatic logic is_reg_jump(input logic [31:0] instr);
        return (instr[31:26] == OP_SPECIAL) &&
               ((instr[5:0] == FN_JR) || (instr[5:0] == FN_JALR));
    endfunction

    // Any instruction that can redirect fetch
    function automatic logic is_ctrl_xfer(input logic [31:0] instr);
        logic result;
        case (instr[31:26])
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: result = 1'b1;
            OP_SPECIAL:                                      result = is_reg_jump(instr);
            default:                                         result = 1'b0;
        endcase
        return result;
    endfunction

    // Control transfers that write the link register (jal / jalr)
    function automatic logic is_link_xfer(input logic [31:0] instr);
        return (instr[31:26] == OP_JAL) ||
               ((instr[31:26] == OP_SPECIAL) && (instr[5:0] == FN_JALR));
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Branch condition evaluator. Unconditional transfers (j, jal, SPECIAL jumps)
// report taken; the caller is responsible for only presenting SPECIAL when
// the funct field is jr/jalr.
module branch_cond_eval
    import mips_ctrl_pkg::*;
(
    input  logic [5:0]  opcode,
    input  logic [31:0] rs,
    input  logic [31:0] rt,
    output logic        taken
);

    logic rs_zero_s;

    assign rs_zero_s = (rs == 32'd0);

    // Condition decode per opcode
    always_comb begin
        taken = 1'b0;
        case (opcode)
            OP_BEQ:     taken = (rs == rt);
            OP_BNE:     taken = (rs != rt);
            OP_BLEZ:    taken = rs[31] | rs_zero_s;
            OP_BGTZ:    taken = ~rs[31] & ~rs_zero_s;
            OP_J,
            OP_JAL,
            OP_SPECIAL: taken = 1'b1;
            default:    taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// Decode-side branch resolution: captures control transfers from fetch,
// resolves them one cycle later with register operands (delay slot in
// flight), and presents a one-or-more-cycle redirect back to fetch.
module branch_resolve_unit
    import mips_ctrl_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h00400000
)(
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_in,
    input  logic [31:0] pc_seq_in,
    input  logic        stall_in,
    input  logic [31:0] rs_data_in,
    input  logic [31:0] rt_data_in,
    output logic [31:0] next_pc_out,
    output logic        jump_branch_out,
    output logic        link_valid_out,
    output logic [31:0] link_addr_out,
    output logic        misalign_out
);

    // RESET_PC is reserved; fetch owns the boot address in this revision.
    if (RESET_PC[1:0] != 2'b00) begin : g_reset_pc_unaligned
    end

    br_state_t   state_r;
    br_state_t   next_state_s;
    logic [31:0] instr_q;
    logic [31:0] pc_seq_q;
    logic [31:0] target_q;
    logic [31:0] link_addr_r;

    logic [5:0]  opcode_s;
    logic        taken_s;
    logic        is_reg_s;
    logic        is_link_s;
    logic        capture_s;
    logic        advance_s;
    logic [31:0] branch_off_s;
    logic [31:0] target_s;

    assign opcode_s     = instr_q[31:26];
    assign is_reg_s     = is_reg_jump(instr_q);
    assign is_link_s    = is_link_xfer(instr_q);
    assign branch_off_s = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
    assign capture_s    = (state_r == ST_IDLE) && !stall_in && is_ctrl_xfer(instr_in);
    assign advance_s    = (state_r == ST_RESOLVE) && !stall_in;

    branch_cond_eval u_cond (
        .opcode (opcode_s),
        .rs     (rs_data_in),
        .rt     (rt_data_in),
        .taken  (taken_s)
    );

    // Redirect target selection for the captured instruction
    always_comb begin
        target_s = pc_seq_q + branch_off_s;
        if (is_reg_s) begin
            target_s = {rs_data_in[31:2], 2'b00};
        end else if ((opcode_s == OP_J) || (opcode_s == OP_JAL)) begin
            target_s = {pc_seq_q[31:28], instr_q[25:0], 2'b00};
        end else begin
            target_s = pc_seq_q + branch_off_s;
        end
    end

    // Next-state logic: IDLE -> RESOLVE -> (REDIRECT) -> IDLE, stalls hold
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (capture_s) begin
                    next_state_s = ST_RESOLVE;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_RESOLVE: begin
                if (!advance_s) begin
                    next_state_s = ST_RESOLVE;
                end else if (taken_s) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_REDIRECT: begin
                if (stall_in) begin
                    next_state_s = ST_REDIRECT;
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            default: next_state_s = ST_IDLE;
        endcase
    end

    // State register; reset aborts any in-flight transfer
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Capture the transfer and its link address, latch the resolved target
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            instr_q     <= 32'd0;
            pc_seq_q    <= 32'd0;
            target_q    <= 32'd0;
            link_addr_r <= 32'd0;
        end else begin
            if (capture_s) begin
                instr_q     <= instr_in;
                pc_seq_q    <= pc_seq_in;
                link_addr_r <= pc_seq_in + 32'd4;
            end
            if (advance_s && taken_s) begin
                target_q <= target_s;
            end
        end
    end

    // Pulses are tied to the advancing RESOLVE cycle so operands are valid
    assign link_valid_out  = advance_s && is_link_s;
    assign misalign_out    = advance_s && is_reg_s && (rs_data_in[1:0] != 2'b00);
    assign link_addr_out   = link_addr_r;
    assign jump_branch_out = (state_r == ST_REDIRECT);
    assign next_pc_out     = (state_r == ST_REDIRECT) ? target_q : pc_seq_in;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Self-checking bench for branch_resolve_unit: directed scenarios followed by
// randomized control-transfer transactions, checked against a transaction-level
// reference model of the MIPS branch/jump rules.
module tb_branch_resolve_unit;

    logic        clk;
    logic        reset;
    logic [31:0] instr_in;
    logic [31:0] pc_seq_in;
    logic        stall_in;
    logic [31:0] rs_data_in;
    logic [31:0] rt_data_in;
    logic [31:0] next_pc_out;
    logic        jump_branch_out;
    logic        link_valid_out;
    logic [31:0] link_addr_out;
    logic        misalign_out;

    int checks = 0;
    int errors = 0;

    branch_resolve_unit dut (
        .clk             (clk),
        .reset           (reset),
        .instr_in        (instr_in),
        .pc_seq_in       (pc_seq_in),
        .stall_in        (stall_in),
        .rs_data_in      (rs_data_in),
        .rt_data_in      (rt_data_in),
        .next_pc_out     (next_pc_out),
        .jump_branch_out (jump_branch_out),
        .link_valid_out  (link_valid_out),
        .link_addr_out   (link_addr_out),
        .misalign_out    (misalign_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model (instruction semantics) ----------------
    function automatic logic ref_is_reg(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] == 6'd8 || ins[5:0] == 6'd9);
    endfunction

    function automatic logic ref_is_ctrl(input logic [31:0] ins);
        int op;
        op = int'(ins[31:26]);
        return (op >= 2 && op <= 7) || ref_is_reg(ins);
    endfunction

    function automatic logic ref_is_link(input logic [31:0] ins);
        return (ins[31:26] == 6'd3) || ((ins[31:26] == 6'd0) && (ins[5:0] == 6'd9));
    endfunction

    function automatic logic ref_taken(input logic [31:0] ins, input logic [31:0] rsv,
                                       input logic [31:0] rtv);
        int op;
        op = int'(ins[31:26]);
        if (op == 4) return rsv == rtv;
        if (op == 5) return rsv != rtv;
        if (op == 6) return $signed(rsv) <= 32'sd0;
        if (op == 7) return $signed(rsv) > 32'sd0;
        return 1'b1;
    endfunction

    function automatic logic [31:0] ref_target(input logic [31:0] ins, input logic [31:0] pcs,
                                               input logic [31:0] rsv);
        logic signed [31:0] off;
        int op;
        op = int'(ins[31:26]);
        if (ref_is_reg(ins)) return rsv & 32'hFFFF_FFFC;
        if (op == 2 || op == 3) return (pcs & 32'hF000_0000) | ((ins & 32'h03FF_FFFF) << 2);
        off = $signed(ins[15:0]);
        return pcs + 32'(off * 32'sd4);
    endfunction

    function automatic logic [31:0] mk_itype(input logic [5:0] op, input logic [15:0] imm);
        return {op, 5'd1, 5'd2, imm};
    endfunction

    function automatic logic [31:0] mk_rtype(input logic [5:0] fn);
        return {6'h00, 5'd3, 5'd0, 5'd31, 5'd0, fn};
    endfunction

    function automatic logic [31:0] pick_val(input logic [31:0] other);
        case ($urandom_range(0, 5))
            0:       return 32'd0;
            1:       return 32'd1;
            2:       return 32'hFFFF_FFFF;
            3:       return 32'h8000_0000;
            4:       return other;
            default: return $urandom();
        endcase
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // Apply inputs at the falling edge, leave time to settle before sampling
    task automatic drive(input logic [31:0] ins, input logic [31:0] pcs, input logic [31:0] rsv,
                         input logic [31:0] rtv, input logic stl);
        @(negedge clk);
        instr_in   = ins;
        pc_seq_in  = pcs;
        rs_data_in = rsv;
        rt_data_in = rtv;
        stall_in   = stl;
        #2;
    endtask

    task automatic chk_quiet(input string tag, input logic [31:0] pcs);
        chk1({tag, ".jb"}, jump_branch_out, 1'b0);
        chk32({tag, ".npc"}, next_pc_out, pcs);
        chk1({tag, ".link"}, link_valid_out, 1'b0);
        chk1({tag, ".mis"}, misalign_out, 1'b0);
    endtask

    // One full transaction: optional stalled presentation, capture, resolve, redirect
    task automatic run_xfer(input string tag, input logic [31:0] ins, input logic [31:0] pcs,
                            input logic [31:0] rsv, input logic [31:0] rtv,
                            input int n_idle_stall, input int n_res_stall, input int n_red_stall);
        logic        tk;
        logic [31:0] tgt;
        logic        stl;
        logic [31:0] rpc;
        for (int k = 0; k < n_idle_stall; k++) begin
            drive(ins, pcs, $urandom(), $urandom(), 1'b1);
            chk_quiet({tag, ".stallidle"}, pcs);
        end
        drive(ins, pcs, $urandom(), $urandom(), 1'b0);
        chk_quiet({tag, ".present"}, pcs);
        if (!ref_is_ctrl(ins)) return;
        tk  = ref_taken(ins, rsv, rtv);
        tgt = ref_target(ins, pcs, rsv);
        for (int k = 0; k <= n_res_stall; k++) begin
            stl = (k < n_res_stall);
            drive($urandom(), pcs + 32'd4, rsv, rtv, stl);
            chk1({tag, ".res.jb"}, jump_branch_out, 1'b0);
            chk32({tag, ".res.npc"}, next_pc_out, pcs + 32'd4);
            chk1({tag, ".res.link"}, link_valid_out, !stl && ref_is_link(ins));
            chk1({tag, ".res.mis"}, misalign_out, !stl && ref_is_reg(ins) && (rsv[1:0] != 2'b00));
            if (!stl && ref_is_link(ins)) chk32({tag, ".res.laddr"}, link_addr_out, pcs + 32'd4);
        end
        if (!tk) return;
        for (int k = 0; k <= n_red_stall; k++) begin
            stl = (k < n_red_stall);
            rpc = $urandom();
            drive($urandom(), rpc, $urandom(), $urandom(), stl);
            chk1({tag, ".red.jb"}, jump_branch_out, 1'b1);
            chk32({tag, ".red.npc"}, next_pc_out, tgt);
            chk1({tag, ".red.link"}, link_valid_out, 1'b0);
            chk1({tag, ".red.mis"}, misalign_out, 1'b0);
        end
    endtask

    initial begin
        logic [31:0] ins;
        logic [31:0] rsv;
        logic [31:0] rtv;
        logic [31:0] r;

        reset      = 1'b0;
        instr_in   = 32'd0;
        pc_seq_in  = 32'd0;
        stall_in   = 1'b0;
        rs_data_in = 32'd0;
        rt_data_in = 32'd0;

        // Reset values, including a branch offered while held in reset
        drive(mk_itype(6'h04, 16'h0003), 32'h0000_1000, 32'd5, 32'd5, 1'b0);
        chk_quiet("rst0", 32'h0000_1000);
        chk32("rst0.laddr", link_addr_out, 32'd0);
        drive(32'd0, 32'h0000_1004, 32'd5, 32'd5, 1'b0);
        chk_quiet("rst1", 32'h0000_1004);
        reset = 1'b1;

        // Directed scenarios
        run_xfer("beq_taken", mk_itype(6'h04, 16'h0003), 32'h0040_0014, 32'd5, 32'd5, 0, 0, 0);
        run_xfer("bne_nt", mk_itype(6'h05, 16'h0010), 32'h0040_0030, 32'd7, 32'd7, 0, 0, 0);
        run_xfer("after_nt", 32'h2108_0001, 32'h0040_0038, 32'd0, 32'd0, 0, 0, 0);
        run_xfer("j", 32'h0810_0040, 32'h0040_0104, 32'd0, 32'd0, 0, 0, 0);
        run_xfer("beq_back", mk_itype(6'h04, 16'hFFFF), 32'h0040_0010, 32'd9, 32'd9, 0, 0, 0);
        run_xfer("jalr_mis", mk_rtype(6'h09), 32'h0040_0200, 32'h0040_0102, 32'd0, 0, 0, 0);
        run_xfer("bgtz_stall", mk_itype(6'h07, 16'h0020), 32'h0040_0300, 32'd1, 32'd0, 0, 0, 3);
        run_xfer("b2b_beq", mk_itype(6'h04, 16'h0040), 32'h0040_0400, 32'd3, 32'd3, 1, 2, 0);
        run_xfer("blez_neg", mk_itype(6'h06, 16'h8000), 32'h0040_0500, 32'h8000_0000, 32'd0, 0, 0, 1);
        run_xfer("bgtz_zero", mk_itype(6'h07, 16'h0004), 32'h0040_0600, 32'd0, 32'd0, 0, 0, 0);
        run_xfer("jal", 32'h0C00_0123, 32'hA000_0010, 32'd0, 32'd0, 0, 1, 0);

        // Reset during RESOLVE of a taken beq aborts the transfer
        drive(mk_itype(6'h04, 16'h0003), 32'h0040_0700, 32'd2, 32'd2, 1'b0);
        @(negedge clk);
        instr_in   = 32'd0;
        pc_seq_in  = 32'h0040_0704;
        reset      = 1'b0;
        #2;
        chk_quiet("rstres", 32'h0040_0704);
        chk32("rstres.laddr", link_addr_out, 32'd0);
        drive(32'd0, 32'h0040_0708, 32'd2, 32'd2, 1'b0);
        chk_quiet("rstres.hold", 32'h0040_0708);
        reset = 1'b1;
        drive(32'd0, 32'h0040_070C, 32'd2, 32'd2, 1'b0);
        chk_quiet("rstres.rel0", 32'h0040_070C);
        chk32("rstres.rel0.laddr", link_addr_out, 32'd0);
        drive(32'd0, 32'h0040_0710, 32'd2, 32'd2, 1'b0);
        chk_quiet("rstres.rel1", 32'h0040_0710);

        // Randomized transactions
        for (int t = 0; t < 300; t++) begin
            r = $urandom();
            case ($urandom_range(0, 9))
                0:       ins = {6'h04, r[25:0]};
                1:       ins = {6'h05, r[25:0]};
                2:       ins = {6'h06, r[25:0]};
                3:       ins = {6'h07, r[25:0]};
                4:       ins = {6'h02, r[25:0]};
                5:       ins = {6'h03, r[25:0]};
                6:       ins = {6'h00, r[25:6], 6'h08};
                7:       ins = {6'h00, r[25:6], 6'h09};
                8:       ins = {6'h00, r[25:6], 6'h20};
                default: ins = r;
            endcase
            rtv = $urandom();
            rsv = pick_val(rtv);
            run_xfer("rand", ins, $urandom(), rsv, rtv,
                     ($urandom_range(0, 3) == 0) ? 1 : 0,
                     int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        drive(32'd0, 32'h0000_2000, 32'd0, 32'd0, 1'b0);
        chk_quiet("final", 32'h0000_2000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
